// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, status codes, FSM states, register defaults.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  localparam int unsigned DEF_SP_IDX = 6;
  localparam int unsigned DEF_RNONE  = 15;

endpackage

// File: rtl/wb_decode.sv
// Raw write-port decode of a retiring instruction, before RNONE and conflict masking.
module wb_decode
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned SP_IDX = DEF_SP_IDX
) (
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic              cnd,
  input  logic [REG_AW-1:0] rA,
  input  logic [REG_AW-1:0] rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              en1_c,
  output logic [REG_AW-1:0] dst1_c,
  output logic [DATA_W-1:0] val1_c,
  output logic              en2_c,
  output logic [REG_AW-1:0] dst2_c,
  output logic [DATA_W-1:0] val2_c,
  output logic              illegal_c
);

  // Map icode to port enables, destinations and data.
  always_comb begin
    en1_c     = 1'b0;
    dst1_c    = '0;
    val1_c    = '0;
    en2_c     = 1'b0;
    dst2_c    = '0;
    val2_c    = '0;
    illegal_c = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RMMOVL, I_JXX: ;
      I_RRMOVL: begin
        // ifun 0 is an unconditional rrmovl
        en1_c  = cnd || (ifun == 4'h0);
        dst1_c = rB;
        val1_c = valE;
      end
      I_IRMOVL, I_OPL: begin
        en1_c  = 1'b1;
        dst1_c = rB;
        val1_c = valE;
      end
      I_MRMOVL: begin
        en1_c  = 1'b1;
        dst1_c = rA;
        val1_c = valM;
      end
      I_CALL, I_RET, I_PUSHL: begin
        en1_c  = 1'b1;
        dst1_c = REG_AW'(SP_IDX);
        val1_c = valE;
      end
      I_POPL: begin
        en1_c  = 1'b1;
        dst1_c = REG_AW'(SP_IDX);
        val1_c = valE;
        en2_c  = 1'b1;
        dst2_c = rA;
        val2_c = valM;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/write_back_ctl.sv
// Y86 write-back stage: register-file write commands, halt/exception FSM, retire counter.
module write_back_ctl
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned SP_IDX = DEF_SP_IDX,
  parameter int unsigned RNONE  = DEF_RNONE,
  parameter int unsigned RET_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic              cnd,
  input  logic [1:0]        stat,
  input  logic [REG_AW-1:0] rA,
  input  logic [REG_AW-1:0] rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              regWrite1,
  output logic [REG_AW-1:0] regReg1,
  output logic [DATA_W-1:0] regValue1,
  output logic              regWrite2,
  output logic [REG_AW-1:0] regReg2,
  output logic [DATA_W-1:0] regValue2,
  output logic              halted,
  output logic [1:0]        status,
  output logic [RET_W-1:0]  retired
);

  wb_state_e         r_state;
  stat_e             r_status;
  logic [RET_W-1:0]  r_retired;
  logic              r_wr1;
  logic              r_wr2;
  logic [REG_AW-1:0] r_reg1;
  logic [REG_AW-1:0] r_reg2;
  logic [DATA_W-1:0] r_val1;
  logic [DATA_W-1:0] r_val2;

  logic              w_en1_raw;
  logic              w_en2_raw;
  logic [REG_AW-1:0] w_dst1;
  logic [REG_AW-1:0] w_dst2;
  logic [DATA_W-1:0] w_val1;
  logic [DATA_W-1:0] w_val2;
  logic              w_illegal;
  logic              w_xfer;
  logic              w_en1;
  logic              w_en2;
  stat_e             w_stat_eff;

  wb_state_e         w_state_nxt;
  stat_e             w_status_nxt;
  logic [RET_W-1:0]  w_retired_nxt;
  logic              w_wr1_nxt;
  logic              w_wr2_nxt;

  wb_decode #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .SP_IDX (SP_IDX)
  ) u_decode (
    .icode     (icode),
    .ifun      (ifun),
    .cnd       (cnd),
    .rA        (rA),
    .rB        (rB),
    .valE      (valE),
    .valM      (valM),
    .en1_c     (w_en1_raw),
    .dst1_c    (w_dst1),
    .val1_c    (w_val1),
    .en2_c     (w_en2_raw),
    .dst2_c    (w_dst2),
    .val2_c    (w_val2),
    .illegal_c (w_illegal)
  );

  assign in_ready   = (r_state == ST_RUN);
  assign w_xfer     = in_valid && in_ready;
  assign w_stat_eff = w_illegal ? S_INS : stat_e'(stat);

  // RNONE suppression, then port 2 wins a same-register conflict.
  assign w_en2 = w_en2_raw && (w_dst2 != REG_AW'(RNONE));
  assign w_en1 = w_en1_raw && (w_dst1 != REG_AW'(RNONE)) &&
                 !(w_en2 && (w_dst1 == w_dst2));

  // Next state, status, retire count and write strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_status_nxt  = r_status;
    w_retired_nxt = r_retired;
    w_wr1_nxt     = 1'b0;
    w_wr2_nxt     = 1'b0;
    if (w_xfer) begin
      if (w_stat_eff != S_AOK) begin
        w_state_nxt  = ST_HALTED;
        w_status_nxt = w_stat_eff;
      end else begin
        w_retired_nxt = r_retired + RET_W'(1);
        w_wr1_nxt     = w_en1;
        w_wr2_nxt     = w_en2;
        if (icode == I_HALT) begin
          w_state_nxt  = ST_HALTED;
          w_status_nxt = S_HLT;
        end
      end
    end
  end

  // State register; reset wins over everything including HALTED.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_status  <= S_AOK;
      r_retired <= '0;
      r_wr1     <= 1'b0;
      r_wr2     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_status  <= w_status_nxt;
      r_retired <= w_retired_nxt;
      r_wr1     <= w_wr1_nxt;
      r_wr2     <= w_wr2_nxt;
    end
  end

  // Destination/data registers hold until their port writes again.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_reg1 <= '0;
      r_val1 <= '0;
      r_reg2 <= '0;
      r_val2 <= '0;
    end else begin
      if (w_wr1_nxt) begin
        r_reg1 <= w_dst1;
        r_val1 <= w_val1;
      end
      if (w_wr2_nxt) begin
        r_reg2 <= w_dst2;
        r_val2 <= w_val2;
      end
    end
  end

  assign regWrite1 = r_wr1;
  assign regReg1   = r_reg1;
  assign regValue1 = r_val1;
  assign regWrite2 = r_wr2;
  assign regReg2   = r_reg2;
  assign regValue2 = r_val2;
  assign halted    = (r_state == ST_HALTED);
  assign status    = r_status;
  assign retired   = r_retired;

endmodule

// File: tb/tb_write_back_ctl.sv
// Directed bench for write_back_ctl.
module tb_write_back_ctl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        cnd;
  logic [1:0]  stat;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [31:0] valE;
  logic [31:0] valM;
  logic        regWrite1;
  logic [3:0]  regReg1;
  logic [31:0] regValue1;
  logic        regWrite2;
  logic [3:0]  regReg2;
  logic [31:0] regValue2;
  logic        halted;
  logic [1:0]  status;
  logic [31:0] retired;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  write_back_ctl dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .cnd       (cnd),
    .stat      (stat),
    .rA        (rA),
    .rB        (rB),
    .valE      (valE),
    .valM      (valM),
    .regWrite1 (regWrite1),
    .regReg1   (regReg1),
    .regValue1 (regValue1),
    .regWrite2 (regWrite2),
    .regReg2   (regReg2),
    .regValue2 (regValue2),
    .halted    (halted),
    .status    (status),
    .retired   (retired)
  );

  // Present one cycle of input; outputs are settled 1 time unit after the edge.
  task automatic issue(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic c, input logic [1:0] st, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] ve, input logic [31:0] vm);
    in_valid = v; icode = ic; ifun = fn; cnd = c; stat = st;
    rA = ra; rB = rb; valE = ve; valM = vm;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL reset_wr1 got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (regWrite2 !== 1'b0) $display("FAIL reset_wr2 got %b exp 0", regWrite2); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else n_pass++;
    n_total++; if (status !== 2'd0) $display("FAIL reset_status got %0d exp 0", status); else n_pass++;
    n_total++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d exp 0", retired); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_irmovl();
    issue(1'b1, 4'h3, 4'h0, 1'b0, 2'd0, 4'hF, 4'd2, 32'h10, 32'h0);
    n_total++; if (regWrite1 !== 1'b1) $display("FAIL irmovl_wr1 got %b exp 1", regWrite1); else n_pass++;
    n_total++; if (regReg1 !== 4'd2) $display("FAIL irmovl_reg1 got %0d exp 2", regReg1); else n_pass++;
    n_total++; if (regValue1 !== 32'h10) $display("FAIL irmovl_val1 got %h exp 10", regValue1); else n_pass++;
    n_total++; if (regWrite2 !== 1'b0) $display("FAIL irmovl_wr2 got %b exp 0", regWrite2); else n_pass++;
    n_total++; if (retired !== 32'd1) $display("FAIL irmovl_retired got %0d exp 1", retired); else n_pass++;
    issue(1'b0, 4'h3, 4'h0, 1'b0, 2'd0, 4'hF, 4'd2, 32'h10, 32'h0);
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL irmovl_pulse got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (regValue1 !== 32'h10) $display("FAIL irmovl_hold got %h exp 10", regValue1); else n_pass++;
  endtask

  task automatic test_cmov();
    issue(1'b1, 4'h2, 4'h1, 1'b0, 2'd0, 4'd1, 4'd3, 32'h44, 32'h0);
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL cmov_nc_wr1 got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (retired !== 32'd2) $display("FAIL cmov_nc_retired got %0d exp 2", retired); else n_pass++;
    issue(1'b1, 4'h2, 4'h1, 1'b1, 2'd0, 4'd1, 4'd3, 32'h55, 32'h0);
    n_total++; if (regWrite1 !== 1'b1) $display("FAIL cmov_c_wr1 got %b exp 1", regWrite1); else n_pass++;
    n_total++; if (regReg1 !== 4'd3) $display("FAIL cmov_c_reg1 got %0d exp 3", regReg1); else n_pass++;
    n_total++; if (regValue1 !== 32'h55) $display("FAIL cmov_c_val1 got %h exp 55", regValue1); else n_pass++;
    issue(1'b1, 4'h2, 4'h0, 1'b0, 2'd0, 4'd1, 4'd4, 32'h66, 32'h0);
    n_total++; if (regWrite1 !== 1'b1) $display("FAIL rrmovl_wr1 got %b exp 1", regWrite1); else n_pass++;
    n_total++; if (regReg1 !== 4'd4) $display("FAIL rrmovl_reg1 got %0d exp 4", regReg1); else n_pass++;
    n_total++; if (retired !== 32'd4) $display("FAIL cmov_retired got %0d exp 4", retired); else n_pass++;
  endtask

  task automatic test_popl();
    issue(1'b1, 4'hB, 4'h0, 1'b0, 2'd0, 4'd1, 4'hF, 32'h104, 32'hAB);
    n_total++; if (regWrite1 !== 1'b1) $display("FAIL popl_wr1 got %b exp 1", regWrite1); else n_pass++;
    n_total++; if (regReg1 !== 4'd6) $display("FAIL popl_reg1 got %0d exp 6", regReg1); else n_pass++;
    n_total++; if (regValue1 !== 32'h104) $display("FAIL popl_val1 got %h exp 104", regValue1); else n_pass++;
    n_total++; if (regWrite2 !== 1'b1) $display("FAIL popl_wr2 got %b exp 1", regWrite2); else n_pass++;
    n_total++; if (regReg2 !== 4'd1) $display("FAIL popl_reg2 got %0d exp 1", regReg2); else n_pass++;
    n_total++; if (regValue2 !== 32'hAB) $display("FAIL popl_val2 got %h exp ab", regValue2); else n_pass++;
    issue(1'b1, 4'hB, 4'h0, 1'b0, 2'd0, 4'd6, 4'hF, 32'h108, 32'h77);
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL popsp_wr1 got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (regWrite2 !== 1'b1) $display("FAIL popsp_wr2 got %b exp 1", regWrite2); else n_pass++;
    n_total++; if (regReg2 !== 4'd6) $display("FAIL popsp_reg2 got %0d exp 6", regReg2); else n_pass++;
    n_total++; if (regValue2 !== 32'h77) $display("FAIL popsp_val2 got %h exp 77", regValue2); else n_pass++;
    n_total++; if (retired !== 32'd6) $display("FAIL popl_retired got %0d exp 6", retired); else n_pass++;
  endtask

  task automatic test_mapping();
    issue(1'b1, 4'h3, 4'h0, 1'b0, 2'd0, 4'hF, 4'hF, 32'h99, 32'h0);
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL rnone_wr1 got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (retired !== 32'd7) $display("FAIL rnone_retired got %0d exp 7", retired); else n_pass++;
    issue(1'b1, 4'h5, 4'h0, 1'b0, 2'd0, 4'd5, 4'd2, 32'h20, 32'hCAFE);
    n_total++; if (regWrite1 !== 1'b1) $display("FAIL mrmovl_wr1 got %b exp 1", regWrite1); else n_pass++;
    n_total++; if (regReg1 !== 4'd5) $display("FAIL mrmovl_reg1 got %0d exp 5", regReg1); else n_pass++;
    n_total++; if (regValue1 !== 32'hCAFE) $display("FAIL mrmovl_val1 got %h exp cafe", regValue1); else n_pass++;
    issue(1'b1, 4'h8, 4'h0, 1'b0, 2'd0, 4'hF, 4'hF, 32'hFC, 32'h0);
    n_total++; if (regReg1 !== 4'd6) $display("FAIL call_reg1 got %0d exp 6", regReg1); else n_pass++;
    n_total++; if (regValue1 !== 32'hFC) $display("FAIL call_val1 got %h exp fc", regValue1); else n_pass++;
    issue(1'b1, 4'h4, 4'h0, 1'b0, 2'd0, 4'd1, 4'd2, 32'h30, 32'h0);
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL rmmovl_wr1 got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (retired !== 32'd10) $display("FAIL map_retired got %0d exp 10", retired); else n_pass++;
  endtask

  task automatic test_exception();
    issue(1'b1, 4'h5, 4'h0, 1'b0, 2'd2, 4'd5, 4'd2, 32'h20, 32'h1);
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL adr_wr1 got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (regWrite2 !== 1'b0) $display("FAIL adr_wr2 got %b exp 0", regWrite2); else n_pass++;
    n_total++; if (halted !== 1'b1) $display("FAIL adr_halted got %b exp 1", halted); else n_pass++;
    n_total++; if (status !== 2'd2) $display("FAIL adr_status got %0d exp 2", status); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL adr_ready got %b exp 0", in_ready); else n_pass++;
    n_total++; if (retired !== 32'd10) $display("FAIL adr_retired got %0d exp 10", retired); else n_pass++;
    issue(1'b1, 4'h3, 4'h0, 1'b0, 2'd0, 4'hF, 4'd2, 32'h11, 32'h0);
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL halted_wr1 got %b exp 0", regWrite1); else n_pass++;
    n_total++; if (retired !== 32'd10) $display("FAIL halted_retired got %0d exp 10", retired); else n_pass++;
    n_total++; if (status !== 2'd2) $display("FAIL halted_status got %0d exp 2", status); else n_pass++;
    do_reset();
    n_total++; if (halted !== 1'b0) $display("FAIL rst2_halted got %b exp 0", halted); else n_pass++;
    n_total++; if (status !== 2'd0) $display("FAIL rst2_status got %0d exp 0", status); else n_pass++;
    n_total++; if (retired !== 32'd0) $display("FAIL rst2_retired got %0d exp 0", retired); else n_pass++;
    issue(1'b1, 4'hC, 4'h0, 1'b0, 2'd0, 4'd1, 4'd2, 32'h5, 32'h0);
    n_total++; if (status !== 2'd3) $display("FAIL ins_status got %0d exp 3", status); else n_pass++;
    n_total++; if (halted !== 1'b1) $display("FAIL ins_halted got %b exp 1", halted); else n_pass++;
    n_total++; if (retired !== 32'd0) $display("FAIL ins_retired got %0d exp 0", retired); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 4'h1, 4'h0, 1'b0, 2'd0, 4'd1, 4'd2, 32'h0, 32'h0);
      n_total++; if (regWrite1 !== 1'b0) $display("FAIL nop_wr1 got %b exp 0", regWrite1); else n_pass++;
    end
    issue(1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 4'd1, 4'd2, 32'h0, 32'h0);
    n_total++; if (retired !== 32'd4) $display("FAIL halt_retired got %0d exp 4", retired); else n_pass++;
    n_total++; if (halted !== 1'b1) $display("FAIL halt_halted got %b exp 1", halted); else n_pass++;
    n_total++; if (status !== 2'd1) $display("FAIL halt_status got %0d exp 1", status); else n_pass++;
    n_total++; if (regWrite1 !== 1'b0) $display("FAIL halt_wr1 got %b exp 0", regWrite1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        v;
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        e1;
    logic        e2;
    logic [31:0] ve;
    int          accepted;
    accepted = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v  = ((i % 4) != 3);
      fn = 4'h0; ra = 4'd1; rb = 4'd2; e2 = 1'b0;
      case (i % 5)
        0: begin ic = 4'h3; e1 = 1'b1; end
        1: begin ic = 4'h1; e1 = 1'b0; end
        2: begin ic = 4'h2; fn = 4'h1; rb = 4'd3; e1 = 1'b1; end
        3: begin ic = 4'hB; e1 = 1'b1; e2 = 1'b1; end
        default: begin ic = 4'h4; e1 = 1'b0; end
      endcase
      if (!v) begin e1 = 1'b0; e2 = 1'b0; end
      ve = 32'h100 + 32'(i);
      if (v) accepted++;
      issue(v, ic, fn, 1'b1, 2'd0, ra, rb, ve, 32'hAB);
      n_total++; if (regWrite1 !== e1) $display("FAIL b2b_wr1[%0d] got %b exp %b", i, regWrite1, e1); else n_pass++;
      n_total++; if (regWrite2 !== e2) $display("FAIL b2b_wr2[%0d] got %b exp %b", i, regWrite2, e2); else n_pass++;
      if (e1) begin
        n_total++; if (regValue1 !== ve) $display("FAIL b2b_val1[%0d] got %h exp %h", i, regValue1, ve); else n_pass++;
      end
    end
    n_total++; if (retired !== 32'd15) $display("FAIL b2b_retired got %0d exp 15", retired); else n_pass++;
    n_total++; if (retired !== 32'(accepted)) $display("FAIL b2b_accepted got %0d exp %0d", retired, accepted); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; icode = '0; ifun = '0; cnd = 1'b0; stat = '0;
    rA = '0; rB = '0; valE = '0; valM = '0;
    test_reset();
    test_irmovl();
    test_cmov();
    test_popl();
    test_mapping();
    test_exception();
    test_halt();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
